// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles both master request ports and the controller user port of sdram_arbiter.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
);
   logic              m0_valid, m0_we, m0_ack;
   logic [3:0]        m0_sel;
   logic [ADDR_W-1:0] m0_adr;
   logic [DATA_W-1:0] m0_dat_i, m0_dat_o;
   logic              m1_valid, m1_we, m1_ack;
   logic [3:0]        m1_sel;
   logic [ADDR_W-1:0] m1_adr;
   logic [DATA_W-1:0] m1_dat_i, m1_dat_o;
   logic [ADDR_W-1:0] ctrl_addr;
   logic              ctrl_rw, ctrl_in_valid, ctrl_busy, ctrl_out_valid;
   logic [DATA_W-1:0] ctrl_data_in, ctrl_data_out;
   logic [3:0]        ctrl_mask;
   logic              grant, rd_err;

   modport slave (
      input  m0_valid, m0_we, m0_sel, m0_adr, m0_dat_i,
      output m0_ack, m0_dat_o,
      input  m1_valid, m1_we, m1_sel, m1_adr, m1_dat_i,
      output m1_ack, m1_dat_o,
      output ctrl_addr, ctrl_rw, ctrl_data_in, ctrl_mask, ctrl_in_valid,
      input  ctrl_busy, ctrl_out_valid, ctrl_data_out,
      output grant, rd_err
   );

   modport master (
      output m0_valid, m0_we, m0_sel, m0_adr, m0_dat_i,
      input  m0_ack, m0_dat_o,
      output m1_valid, m1_we, m1_sel, m1_adr, m1_dat_i,
      input  m1_ack, m1_dat_o,
      input  ctrl_addr, ctrl_rw, ctrl_data_in, ctrl_mask, ctrl_in_valid,
      output ctrl_busy, ctrl_out_valid, ctrl_data_out,
      input  grant, rd_err
   );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of the sdram_controller user port between two masters.
// Define SDRAM_ARB_TIMEOUT_EN to bound RD_WAIT by RD_TIMEOUT cycles (rd_err + 32'hDEADBEEF on expiry).
module sdram_arbiter #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
`ifdef SDRAM_ARB_TIMEOUT_EN
   , parameter int RD_TIMEOUT = 255
`endif
) (
   input  logic           wb_clk_i,
   input  logic           rst_n,
   sdram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, DONE} state_t;

   state_t            state_q;
   logic              ptr_q, grant_q, we_q, in_valid_q, m0_ack_q, m1_ack_q, rd_err_q;
   logic [3:0]        mask_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdat_q, m0_dat_q, m1_dat_q;
   logic              pick, pick_we, timeout, rd_done;
   logic [DATA_W-1:0] rd_data;

   assign pick    = bus.m1_valid & (~bus.m0_valid | ptr_q);
   assign pick_we = pick ? bus.m1_we : bus.m0_we;
   assign rd_done = bus.ctrl_out_valid | timeout;
   assign rd_data = bus.ctrl_out_valid ? bus.ctrl_data_out : DATA_W'(32'hDEADBEEF);

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(RD_TIMEOUT + 1) > 8 ? $clog2(RD_TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] cnt_q;
   assign timeout = ~bus.ctrl_out_valid & (cnt_q == CNT_W'(RD_TIMEOUT - 1));
   // Cycles spent in RD_WAIT; zero outside it so it starts clean on every entry.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= (state_q == RD_WAIT) ? cnt_q + 1'b1 : '0;
   end
`else
   assign timeout = 1'b0;
`endif

   // Arbitration, request latching and controller handshake sequencing with registered outputs.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         grant_q    <= 1'b0;
         we_q       <= 1'b0;
         mask_q     <= '0;
         adr_q      <= '0;
         wdat_q     <= '0;
         in_valid_q <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_dat_q   <= '0;
         m1_dat_q   <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.m0_valid | bus.m1_valid) begin
               grant_q    <= pick;
               ptr_q      <= ~pick;
               we_q       <= pick_we;
               mask_q     <= (pick ? bus.m1_sel : bus.m0_sel) & {4{pick_we}};
               adr_q      <= pick ? bus.m1_adr : bus.m0_adr;
               wdat_q     <= pick ? bus.m1_dat_i : bus.m0_dat_i;
               in_valid_q <= 1'b1;
               state_q    <= ISSUE;
            end
            ISSUE: if (!bus.ctrl_busy) begin
               in_valid_q <= 1'b0;
               state_q    <= we_q ? DONE : RD_WAIT;
               m0_ack_q   <= we_q & ~grant_q;
               m1_ack_q   <= we_q & grant_q;
            end
            RD_WAIT: if (rd_done) begin
               state_q  <= DONE;
               m0_ack_q <= ~grant_q;
               m1_ack_q <= grant_q;
               rd_err_q <= timeout;
               if (grant_q) m1_dat_q <= rd_data;
               else         m0_dat_q <= rd_data;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ctrl_addr     = adr_q;
   assign bus.ctrl_rw       = we_q;
   assign bus.ctrl_data_in  = wdat_q;
   assign bus.ctrl_mask     = mask_q;
   assign bus.ctrl_in_valid = in_valid_q;
   assign bus.m0_ack        = m0_ack_q;
   assign bus.m1_ack        = m1_ack_q;
   assign bus.m0_dat_o      = m0_dat_q;
   assign bus.m1_dat_o      = m1_dat_q;
   assign bus.grant         = grant_q;
   assign bus.rd_err        = rd_err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errs = 0;
   int   checks = 0;

   sdram_arbiter_if #(.ADDR_W(23), .DATA_W(32)) bus ();

`ifdef SDRAM_ARB_TIMEOUT_EN
   sdram_arbiter #(.ADDR_W(23), .DATA_W(32), .RD_TIMEOUT(16)) dut (.wb_clk_i(clk), .rst_n(rst_n), .bus(bus));
`else
   sdram_arbiter #(.ADDR_W(23), .DATA_W(32)) dut (.wb_clk_i(clk), .rst_n(rst_n), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.m0_valid = 0; bus.m0_we = 0; bus.m0_sel = 0; bus.m0_adr = 0; bus.m0_dat_i = 0;
      bus.m1_valid = 0; bus.m1_we = 0; bus.m1_sel = 0; bus.m1_adr = 0; bus.m1_dat_i = 0;
      bus.ctrl_busy = 0; bus.ctrl_out_valid = 0; bus.ctrl_data_out = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      cyc(); cyc();
      checks++; if ({bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack, bus.grant, bus.rd_err, bus.ctrl_rw} !== 6'b0) begin errs++; $display("FAIL reset_flags got=%b exp=000000", {bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack, bus.grant, bus.rd_err, bus.ctrl_rw}); end
      checks++; if ({bus.ctrl_addr, bus.ctrl_mask, bus.ctrl_data_in} !== 59'h0) begin errs++; $display("FAIL reset_ctrl got=%h/%h/%h exp=0", bus.ctrl_addr, bus.ctrl_mask, bus.ctrl_data_in); end
      checks++; if ({bus.m0_dat_o, bus.m1_dat_o} !== 64'h0) begin errs++; $display("FAIL reset_dat got=%h/%h exp=0", bus.m0_dat_o, bus.m1_dat_o); end
      rst_n = 1;
      cyc();
   endtask

   task automatic test_write();
      bus.m0_valid = 1; bus.m0_we = 1; bus.m0_sel = 4'hF; bus.m0_adr = 23'h000010; bus.m0_dat_i = 32'hA5A5A5A5;
      cyc();
      checks++; if ({bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack, bus.grant, bus.ctrl_rw} !== 5'b10001) begin errs++; $display("FAIL wr_c1_flags got=%b exp=10001", {bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack, bus.grant, bus.ctrl_rw}); end
      checks++; if (bus.ctrl_addr !== 23'h000010) begin errs++; $display("FAIL wr_addr got=%h exp=000010", bus.ctrl_addr); end
      checks++; if (bus.ctrl_data_in !== 32'hA5A5A5A5) begin errs++; $display("FAIL wr_data got=%h exp=a5a5a5a5", bus.ctrl_data_in); end
      checks++; if (bus.ctrl_mask !== 4'hF) begin errs++; $display("FAIL wr_mask got=%h exp=f", bus.ctrl_mask); end
      cyc();
      checks++; if ({bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack} !== 3'b010) begin errs++; $display("FAIL wr_c2_ack got=%b exp=010", {bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack}); end
      bus.m0_valid = 0;
      cyc();
      checks++; if ({bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack} !== 3'b000) begin errs++; $display("FAIL wr_c3_idle got=%b exp=000", {bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack}); end
   endtask

   task automatic test_read();
      int ivc = 0;
      bus.m0_valid = 1; bus.m0_we = 0; bus.m0_sel = 4'hF; bus.m0_adr = 23'h000010;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         ivc += int'(bus.ctrl_in_valid);
         if (c == 1) begin
            checks++; if ({bus.ctrl_rw, bus.ctrl_mask} !== 5'b0) begin errs++; $display("FAIL rd_rw_mask got=%b exp=00000", {bus.ctrl_rw, bus.ctrl_mask}); end
         end
         checks++; if (bus.m0_ack !== (c == 7) || bus.m1_ack !== 1'b0 || bus.rd_err !== 1'b0) begin errs++; $display("FAIL rd_ack c=%0d got=%b%b%b exp=%b00", c, bus.m0_ack, bus.m1_ack, bus.rd_err, c == 7); end
         if (c == 7) begin
            checks++; if (bus.m0_dat_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL rd_data got=%h exp=a5a5a5a5", bus.m0_dat_o); end
            bus.m0_valid = 0;
         end
         bus.ctrl_out_valid = (c == 6);
         bus.ctrl_data_out  = (c == 6) ? 32'hA5A5A5A5 : 32'h0;
      end
      checks++; if (ivc !== 1) begin errs++; $display("FAIL rd_in_valid_cycles got=%0d exp=1", ivc); end
   endtask

   task automatic test_round_robin();
      int n = 0;
      rst_n = 0; cyc(); rst_n = 1;
      bus.m0_valid = 1; bus.m0_we = 1; bus.m0_sel = 4'hF; bus.m0_adr = 23'h000100; bus.m0_dat_i = 32'h11111111;
      bus.m1_valid = 1; bus.m1_we = 1; bus.m1_sel = 4'hF; bus.m1_adr = 23'h000200; bus.m1_dat_i = 32'h22222222;
      for (int c = 1; c <= 30 && n < 4; c++) begin
         cyc();
         checks++; if ((bus.m0_ack & bus.m1_ack) !== 1'b0) begin errs++; $display("FAIL rr_double_ack c=%0d got=11 exp=not_both", c); end
         if (bus.m0_ack | bus.m1_ack) begin
            checks++; if (bus.m1_ack !== n[0] || bus.grant !== n[0]) begin errs++; $display("FAIL rr_order n=%0d got=m1ack%b grant%b exp=%b", n, bus.m1_ack, bus.grant, n[0]); end
            checks++; if (bus.ctrl_addr !== (n[0] ? 23'h000200 : 23'h000100)) begin errs++; $display("FAIL rr_addr n=%0d got=%h", n, bus.ctrl_addr); end
            n++;
         end
      end
      checks++; if (n !== 4) begin errs++; $display("FAIL rr_ack_count got=%0d exp=4", n); end
      bus.m0_valid = 0; bus.m1_valid = 0;
      cyc(); cyc();
   endtask

   task automatic test_busy();
      bus.m1_valid = 1; bus.m1_we = 1; bus.m1_sel = 4'h3; bus.m1_adr = 23'h001234; bus.m1_dat_i = 32'h0BADF00D;
      bus.ctrl_busy = 1;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         checks++; if (bus.ctrl_in_valid !== (c <= 8) || bus.m1_ack !== (c == 9) || bus.m0_ack !== 1'b0) begin errs++; $display("FAIL busy c=%0d got=iv%b a1%b a0%b", c, bus.ctrl_in_valid, bus.m1_ack, bus.m0_ack); end
         if (c <= 9) begin
            checks++; if (bus.ctrl_addr !== 23'h001234 || bus.grant !== 1'b1 || bus.ctrl_mask !== 4'h3) begin errs++; $display("FAIL busy_stable c=%0d got=%h/%b/%h exp=001234/1/3", c, bus.ctrl_addr, bus.grant, bus.ctrl_mask); end
         end
         if (c == 9) bus.m1_valid = 0;
         bus.ctrl_busy = (c <= 7);
      end
   endtask

   task automatic test_reset_mid();
      bus.m0_valid = 1; bus.m0_we = 0; bus.m0_sel = 4'hF; bus.m0_adr = 23'h000077;
      cyc(); cyc(); cyc();
      rst_n = 0;
      #2;
      checks++; if ({bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack, bus.grant} !== 4'b0) begin errs++; $display("FAIL midrst_flags got=%b exp=0000", {bus.ctrl_in_valid, bus.m0_ack, bus.m1_ack, bus.grant}); end
      bus.m0_valid = 0;
      cyc();
      rst_n = 1;
      bus.m0_valid = 1; bus.m0_we = 1; bus.m0_sel = 4'hF; bus.m0_adr = 23'h000300; bus.m0_dat_i = 32'h33333333;
      bus.m1_valid = 1; bus.m1_we = 0; bus.m1_sel = 4'hF; bus.m1_adr = 23'h000055;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         checks++; if (bus.m0_ack !== (c == 2) || bus.m1_ack !== (c == 6) || bus.ctrl_in_valid !== (c == 1 || c == 4)) begin errs++; $display("FAIL midrst_seq c=%0d got=a0%b a1%b iv%b", c, bus.m0_ack, bus.m1_ack, bus.ctrl_in_valid); end
         if (c == 1) begin checks++; if (bus.grant !== 1'b0) begin errs++; $display("FAIL midrst_ptr got=%b exp=0", bus.grant); end end
         if (c == 4) begin checks++; if (bus.grant !== 1'b1 || bus.ctrl_addr !== 23'h000055) begin errs++; $display("FAIL midrst_m1 got=%b/%h exp=1/000055", bus.grant, bus.ctrl_addr); end end
         if (c == 6) begin checks++; if (bus.m1_dat_o !== 32'hCAFEF00D) begin errs++; $display("FAIL midrst_data got=%h exp=cafef00d", bus.m1_dat_o); end end
         if (c == 2) bus.m0_valid = 0;
         if (c == 6) bus.m1_valid = 0;
         bus.ctrl_out_valid = (c == 5);
         bus.ctrl_data_out  = (c == 5) ? 32'hCAFEF00D : 32'h0;
      end
   endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bus.m1_valid = 1; bus.m1_we = 0; bus.m1_sel = 4'hF; bus.m1_adr = 23'h000400;
      for (int c = 1; c <= 22; c++) begin
         cyc();
         checks++; if (bus.m1_ack !== (c == 18) || bus.rd_err !== (c == 18) || bus.m0_ack !== 1'b0) begin errs++; $display("FAIL to_seq c=%0d got=a1%b err%b a0%b", c, bus.m1_ack, bus.rd_err, bus.m0_ack); end
         if (c == 18) begin
            checks++; if (bus.m1_dat_o !== 32'hDEADBEEF) begin errs++; $display("FAIL to_data got=%h exp=deadbeef", bus.m1_dat_o); end
            bus.m1_valid = 0;
         end
         if (c >= 20) begin checks++; if (bus.ctrl_in_valid !== 1'b0 || bus.m1_dat_o !== 32'hDEADBEEF) begin errs++; $display("FAIL to_late c=%0d got=iv%b dat=%h", c, bus.ctrl_in_valid, bus.m1_dat_o); end end
         bus.ctrl_out_valid = (c == 19);
         bus.ctrl_data_out  = (c == 19) ? 32'h12345678 : 32'h0;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_busy();
      test_reset_mid();
`ifdef SDRAM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-master arbiter that shares the single sdram_controller user port between master 0 (CPU Wishbone path) and master 1 (DMA/prefetch engine). It latches one request at a time, sequences the controller's in_valid/busy/out_valid protocol, and returns one ack pulse plus read data to the granted master. It sits between the Wishbone decode and the controller/sdr pair; the controller and sdr are unchanged.

Parameters:
ADDR_W, 23, controller user address width
DATA_W, 32, data width
RD_TIMEOUT, 255, max cycles in RD_WAIT before forced completion (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_valid  in  1  master 0 request; held with payload stable until m0_ack
m0_we  in  1  1=write, 0=read
m0_sel  in  4  byte enables
m0_adr  in  ADDR_W  word address
m0_dat_i  in  DATA_W  write data
m0_ack  out  1  one-cycle completion pulse
m0_dat_o  out  DATA_W  read data, valid while m0_ack=1
m1_*  same set as m0_* for master 1
ctrl_addr  out  ADDR_W  to controller user_addr
ctrl_rw  out  1  to controller rw
ctrl_data_in  out  DATA_W  to controller data_in
ctrl_mask  out  4  to sdr Dqm: latched sel & {4{we}}
ctrl_in_valid  out  1  to controller in_valid
ctrl_busy  in  1  from controller busy
ctrl_out_valid  in  1  from controller out_valid
ctrl_data_out  in  DATA_W  from controller data_out
grant  out  1  index of master owning the current transaction
rd_err  out  1  one-cycle pulse on read timeout (0 when feature compiled out)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, priority pointer = master 0. Mid-transaction reset drops ctrl_in_valid immediately; no ack is issued for the aborted request.
- States: IDLE, ISSUE, RD_WAIT, DONE.
- IDLE: if exactly one valid, grant it. If both are valid, grant the master the pointer favours; the pointer then flips to the other master (round robin). Latch we/sel/adr/dat_i into registers driving ctrl_*; go to ISSUE. If none is valid, stay.
- ISSUE: ctrl_in_valid=1 (registered, asserted from the first ISSUE cycle). Stay while ctrl_busy=1. On the first cycle with ctrl_busy=0, the controller accepts. Writes go to DONE; reads go to RD_WAIT with ctrl_in_valid=0 on the next cycle (exactly one accepted in_valid per read).
- RD_WAIT: ctrl_in_valid=0. On ctrl_out_valid, capture ctrl_data_out into the granted master's dat_o register and go to DONE.
- DONE: granted master's ack=1 for exactly this cycle; dat_o holds read data (writes: dat_o unchanged). Next state is IDLE. The acked master's valid is ignored in DONE, so a held valid is never double-served.
- Latency:
  - Write, idle controller: valid at cycle 0 → ISSUE 1 → DONE/ack at cycle 2.
  - Read: ack one cycle after ctrl_out_valid.
- ctrl_mask is 0 for reads.
- ctrl_addr, ctrl_rw and ctrl_data_in are stable from ISSUE entry through DONE.
- A request arriving while the other master is in service waits. The pointer guarantees it is served next.
- Non-granted master's ack is always 0. The two acks are never both high.

Optional Feature:
SDRAM_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter (sized for RD_TIMEOUT) clears on RD_WAIT entry and increments each RD_WAIT cycle.
  - When it reaches RD_TIMEOUT without ctrl_out_valid, go to DONE with dat_o=32'hDEADBEEF and rd_err=1 for that DONE cycle.
  - A ctrl_out_valid arriving later while in IDLE is ignored.
- Undefined: no counter; RD_WAIT waits indefinitely; rd_err tied 0.

Test Plan:
- m0 write adr=0x000010 dat=0xA5A5A5A5 sel=0xF, busy=0 → ctrl_in_valid at cycle 1, m0_ack at cycle 2, ctrl_mask=0xF.
- m0 read adr=0x000010, model returns out_valid 5 cycles after accept with 0xA5A5A5A5 → exactly one in_valid cycle; m0_ack one cycle after out_valid; m0_dat_o=0xA5A5A5A5.
- m0 and m1 both valid from reset (writes), held after ack → grant sequence 0,1,0,1; acks alternate; no double ack.
- busy=1 for 7 cycles during ISSUE → ctrl_in_valid stays high 8 cycles and ctrl_addr stays stable; ack 1 cycle after busy falls.
- rst_n pulsed low during RD_WAIT → ctrl_in_valid, acks and grant are 0 immediately; after release, pointer=0 and a fresh m1 read is served normally.
- With SDRAM_ARB_TIMEOUT_EN, RD_TIMEOUT=16, no out_valid → m1_ack and rd_err at cycle 16 after RD_WAIT entry, m1_dat_o=0xDEADBEEF.
